// File: rtl/can_pkg.sv
// Shared types for the CAN transmit scheduler: FSM states, mailbox record,
// and the arbitration-key builder (lower key wins on the bus).
package can_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    RETRY  = 3'd4
  } tx_sched_state_e;

  typedef logic [31:0] can_arb_key_t;

  typedef struct packed {
    logic [10:0] id_std;
    logic [17:0] id_ext;
    logic        ide;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
  } can_mb_t;

  // Bit order mirrors the on-wire arbitration field: base id, RTR/SRR, IDE, ext id, RTR.
  function automatic can_arb_key_t mk_arb_key(input can_mb_t mb);
    return {mb.id_std,
            (mb.ide ? 1'b1 : mb.rtr),
            mb.ide,
            (mb.ide ? mb.id_ext : 18'h0),
            (mb.ide ? mb.rtr : 1'b0)};
  endfunction

endpackage

// File: rtl/can_tx_prio_select.sv
// Combinational minimum-key finder; ties resolve to the lowest mailbox index.
module can_tx_prio_select
  import can_pkg::*;
#(
  parameter int NUM_MB = 4
) (
  input  can_arb_key_t               keys_i [NUM_MB],
  input  logic [NUM_MB-1:0]          valid_i,
  output logic [$clog2(NUM_MB)-1:0]  win_idx_o,
  output logic                       found_o
);

  localparam int IDX_W = $clog2(NUM_MB);

  can_arb_key_t       best_key_s;
  logic [IDX_W-1:0]   best_idx_s;
  logic               found_s;

  // Linear scan with strict less-than keeps the earlier index on ties.
  always_comb begin
    best_key_s = '1;
    best_idx_s = '0;
    found_s    = 1'b0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (valid_i[i] && (!found_s || (keys_i[i] < best_key_s))) begin
        best_key_s = keys_i[i];
        best_idx_s = IDX_W'(i);
        found_s    = 1'b1;
      end else begin
        best_key_s = best_key_s;
      end
    end
    win_idx_o = best_idx_s;
    found_o   = found_s;
  end

endmodule

// File: rtl/can_tx_scheduler.sv
// Multi-mailbox CAN transmit scheduler. Define CAN_TX_SINGLE_SHOT_EN to drop
// frames on the first arbitration loss instead of retrying.
module can_tx_scheduler
  import can_pkg::*;
#(
  parameter int NUM_MB    = 4,
  parameter int MAX_RETRY = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [$clog2(NUM_MB)-1:0] wr_sel,
  input  logic [10:0]               wr_id_std,
  input  logic [17:0]               wr_id_ext,
  input  logic                      wr_ide,
  input  logic                      wr_rtr,
  input  logic [3:0]                wr_dlc,
  input  logic [63:0]               wr_data,
  input  logic [NUM_MB-1:0]         abort_req,
  input  logic                      tx_done,
  input  logic                      arb_lost,
  output logic                      start_tx,
  output logic [10:0]               tx_id_std,
  output logic [17:0]               tx_id_ext,
  output logic                      tx_ide,
  output logic                      tx_rtr1,
  output logic                      tx_rtr2,
  output logic                      tx_remote_req,
  output logic [3:0]                tx_dlc,
  output logic [63:0]               tx_data,
  output logic [NUM_MB-1:0]         pending,
  output logic [NUM_MB-1:0]         tx_ok,
  output logic [NUM_MB-1:0]         tx_fail,
  output logic [NUM_MB-1:0]         tx_aborted,
  output logic                      wr_err,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_MB);
  localparam int CNT_W = 8;

  tx_sched_state_e    state_q, state_d;
  can_mb_t            mb_q [NUM_MB];
  can_mb_t            fld_q;
  logic               rtr1_q;
  logic [NUM_MB-1:0]  pending_q, pending_d;
  logic [NUM_MB-1:0]  ok_q, ok_d, fail_q, fail_d, abrt_q, abrt_d;
  logic [IDX_W-1:0]   act_idx_q, act_idx_d;
  logic               abort_lat_q, abort_lat_d;
  logic               start_q, busy_q, wr_err_q, wr_err_d;
  logic               wr_store_s, ld_fld_s, act_vld_s;
  logic [IDX_W-1:0]   act_s, win_idx_s;
  logic               found_s;
  can_arb_key_t       keys_s [NUM_MB];
`ifndef CAN_TX_SINGLE_SHOT_EN
  logic [CNT_W-1:0]   retry_q [NUM_MB];
  logic [CNT_W-1:0]   retry_d [NUM_MB];
  logic [CNT_W-1:0]   retry_inc_s;
`endif

  // Arbitration keys for every mailbox.
  always_comb begin
    for (int i = 0; i < NUM_MB; i++) begin
      keys_s[i] = mk_arb_key(mb_q[i]);
    end
  end

  can_tx_prio_select #(.NUM_MB(NUM_MB)) u_prio (
    .keys_i    (keys_s),
    .valid_i   (pending_q),
    .win_idx_o (win_idx_s),
    .found_o   (found_s)
  );

  // In SELECT the winner is already treated as active so an abort there is latched, not applied.
  assign act_s     = (state_q == SELECT) ? win_idx_s : act_idx_q;
  assign act_vld_s = (state_q != IDLE) && !((state_q == SELECT) && !found_s);

  // Next-state, pending bookkeeping and result pulses.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    abort_lat_d = abort_lat_q;
    act_idx_d   = act_idx_q;
    ok_d        = '0;
    fail_d      = '0;
    abrt_d      = '0;
    wr_err_d    = 1'b0;
    wr_store_s  = 1'b0;
    ld_fld_s    = 1'b0;
`ifndef CAN_TX_SINGLE_SHOT_EN
    retry_d     = retry_q;
    retry_inc_s = retry_q[act_idx_q] + CNT_W'(1);
`endif

    if (wr_en) begin
      if (pending_q[wr_sel]) begin
        wr_err_d = 1'b1;
      end else begin
        pending_d[wr_sel] = 1'b1;
        wr_store_s        = 1'b1;
`ifndef CAN_TX_SINGLE_SHOT_EN
        retry_d[wr_sel]   = '0;
`endif
      end
    end else begin
      wr_err_d = 1'b0;
    end

    for (int i = 0; i < NUM_MB; i++) begin
      if (abort_req[i] && pending_q[i]) begin
        if (act_vld_s && (act_s == IDX_W'(i))) begin
          abort_lat_d = 1'b1;
        end else begin
          pending_d[i] = 1'b0;
          abrt_d[i]    = 1'b1;
        end
      end else begin
        abrt_d[i] = abrt_d[i];
      end
    end

    case (state_q)
      IDLE: begin
        abort_lat_d = 1'b0;
        if (|pending_q) begin
          state_d = SELECT;
        end else begin
          state_d = IDLE;
        end
      end
      SELECT: begin
        if (found_s) begin
          act_idx_d = win_idx_s;
          ld_fld_s  = 1'b1;
          state_d   = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (tx_done) begin
          pending_d[act_idx_q] = 1'b0;
          ok_d[act_idx_q]      = 1'b1;
`ifndef CAN_TX_SINGLE_SHOT_EN
          retry_d[act_idx_q]   = '0;
`endif
          state_d = IDLE;
        end else if (arb_lost) begin
          state_d = RETRY;
        end else begin
          state_d = WAIT;
        end
      end
      RETRY: begin
        state_d = IDLE;
        if (abort_lat_q || abort_req[act_idx_q]) begin
          pending_d[act_idx_q] = 1'b0;
          abrt_d[act_idx_q]    = 1'b1;
`ifndef CAN_TX_SINGLE_SHOT_EN
          retry_d[act_idx_q]   = '0;
`endif
        end else begin
`ifdef CAN_TX_SINGLE_SHOT_EN
          pending_d[act_idx_q] = 1'b0;
          fail_d[act_idx_q]    = 1'b1;
`else
          if ((MAX_RETRY != 0) && (retry_inc_s == CNT_W'(MAX_RETRY))) begin
            pending_d[act_idx_q] = 1'b0;
            fail_d[act_idx_q]    = 1'b1;
            retry_d[act_idx_q]   = '0;
          end else begin
            retry_d[act_idx_q] = retry_inc_s;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, mailbox storage and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      abort_lat_q <= 1'b0;
      act_idx_q   <= '0;
      fld_q       <= '0;
      rtr1_q      <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      ok_q        <= '0;
      fail_q      <= '0;
      abrt_q      <= '0;
      wr_err_q    <= 1'b0;
      for (int i = 0; i < NUM_MB; i++) begin
        mb_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      abort_lat_q <= abort_lat_d;
      act_idx_q   <= act_idx_d;
      start_q     <= (state_d == START);
      busy_q      <= (state_d == START) || (state_d == WAIT) || (state_d == RETRY);
      ok_q        <= ok_d;
      fail_q      <= fail_d;
      abrt_q      <= abrt_d;
      wr_err_q    <= wr_err_d;
      if (wr_store_s) begin
        mb_q[wr_sel] <= '{id_std: wr_id_std, id_ext: wr_id_ext, ide: wr_ide,
                          rtr: wr_rtr, dlc: wr_dlc, data: wr_data};
      end
      if (ld_fld_s) begin
        fld_q  <= mb_q[win_idx_s];
        rtr1_q <= mb_q[win_idx_s].ide | mb_q[win_idx_s].rtr;
      end
    end
  end

`ifndef CAN_TX_SINGLE_SHOT_EN
  // Per-mailbox arbitration-loss counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_MB; i++) begin
        retry_q[i] <= '0;
      end
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  assign start_tx      = start_q;
  assign busy          = busy_q;
  assign pending       = pending_q;
  assign tx_ok         = ok_q;
  assign tx_fail       = fail_q;
  assign tx_aborted    = abrt_q;
  assign wr_err        = wr_err_q;
  assign tx_id_std     = fld_q.id_std;
  assign tx_id_ext     = fld_q.id_ext;
  assign tx_ide        = fld_q.ide;
  assign tx_rtr1       = rtr1_q;
  assign tx_rtr2       = fld_q.rtr;
  assign tx_remote_req = fld_q.rtr;
  assign tx_dlc        = fld_q.dlc;
  assign tx_data       = fld_q.data;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Directed self-checking bench for can_tx_scheduler (NUM_MB=4, MAX_RETRY=2).
module tb_can_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst, wr_en, wr_ide, wr_rtr, tx_done, arb_lost;
  logic [1:0]  wr_sel;
  logic [10:0] wr_id_std;
  logic [17:0] wr_id_ext;
  logic [3:0]  wr_dlc, abort_req;
  logic [63:0] wr_data;
  logic        start_tx, tx_ide, tx_rtr1, tx_rtr2, tx_remote_req, wr_err, busy;
  logic [10:0] tx_id_std;
  logic [17:0] tx_id_ext;
  logic [3:0]  tx_dlc, pending, tx_ok, tx_fail, tx_aborted;
  logic [63:0] tx_data;

  int n_chk  = 0;
  int n_fail = 0;
  int n_start;

  can_tx_scheduler #(.NUM_MB(4), .MAX_RETRY(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_id_std(wr_id_std),
    .wr_id_ext(wr_id_ext), .wr_ide(wr_ide), .wr_rtr(wr_rtr), .wr_dlc(wr_dlc),
    .wr_data(wr_data), .abort_req(abort_req), .tx_done(tx_done), .arb_lost(arb_lost),
    .start_tx(start_tx), .tx_id_std(tx_id_std), .tx_id_ext(tx_id_ext), .tx_ide(tx_ide),
    .tx_rtr1(tx_rtr1), .tx_rtr2(tx_rtr2), .tx_remote_req(tx_remote_req), .tx_dlc(tx_dlc),
    .tx_data(tx_data), .pending(pending), .tx_ok(tx_ok), .tx_fail(tx_fail),
    .tx_aborted(tx_aborted), .wr_err(wr_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] sel, input logic [10:0] sid, input logic [17:0] eid,
                      input logic ide, input logic rtr, input logic [3:0] dlc, input logic [63:0] d);
    wr_sel = sel; wr_id_std = sid; wr_id_ext = eid; wr_ide = ide;
    wr_rtr = rtr; wr_dlc = dlc; wr_data = d; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  // Bounded wait for the next start pulse; a timeout shows up as a failed check.
  task automatic wait_start(input string tag);
    for (int i = 0; i < 20 && !start_tx; i++) step();
    check(tag, start_tx, 1);
  endtask

  // From the START cycle: enter WAIT, pulse tx_done, land in the result cycle.
  task automatic finish_done();
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_id_std = '0; wr_id_ext = '0;
    wr_ide = 1'b0; wr_rtr = 1'b0; wr_dlc = '0; wr_data = '0;
    abort_req = '0; tx_done = 1'b0; arb_lost = 1'b0;
    step(); step();
    check("rst_start", start_tx, 0);
    check("rst_busy", busy, 0);
    check("rst_pending", pending, 0);
    check("rst_id", tx_id_std, 0);
    rst = 1'b0;
    step();

    // Basic send with T+3 latency
    load(2'd0, 11'h123, 18'h0, 1'b0, 1'b0, 4'd2, 64'hCDAB);
    check("t1_pend", pending, 4'b0001);
    check("t1_start_t1", start_tx, 0);
    step();
    check("t1_start_t2", start_tx, 0);
    step();
    check("t1_start_t3", start_tx, 1);
    check("t1_busy", busy, 1);
    check("t1_id", tx_id_std, 11'h123);
    check("t1_rtr1", tx_rtr1, 0);
    check("t1_dlc", tx_dlc, 4'd2);
    check("t1_data", tx_data, 64'hCDAB);
    step();
    check("t1_start_once", start_tx, 0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("t1_ok", tx_ok, 4'b0001);
    check("t1_pend_clr", pending, 0);
    check("t1_busy_clr", busy, 0);
    step();
    check("t1_ok_pulse", tx_ok, 0);

    // Priority: lower id wins regardless of mailbox index
    load(2'd0, 11'h200, 18'h0, 1'b0, 1'b0, 4'd0, 64'h0);
    load(2'd2, 11'h100, 18'h0, 1'b0, 1'b0, 4'd0, 64'h0);
    wait_start("t2_start_a");
    check("t2_first_id", tx_id_std, 11'h100);
    finish_done();
    check("t2_ok_a", tx_ok, 4'b0100);
    wait_start("t2_start_b");
    check("t2_second_id", tx_id_std, 11'h200);
    finish_done();
    check("t2_ok_b", tx_ok, 4'b0001);

    // Standard beats extended with the same base id
    load(2'd3, 11'h155, 18'h0, 1'b1, 1'b0, 4'd1, 64'h0);
    load(2'd1, 11'h155, 18'h0, 1'b0, 1'b0, 4'd1, 64'h0);
    wait_start("t3_start_a");
    check("t3_std_ide", tx_ide, 0);
    finish_done();
    check("t3_ok_a", tx_ok, 4'b0010);
    wait_start("t3_start_b");
    check("t3_ext_ide", tx_ide, 1);
    check("t3_ext_rtr1", tx_rtr1, 1);
    check("t3_ext_rtr2", tx_rtr2, 0);
    finish_done();
    check("t3_ok_b", tx_ok, 4'b1000);

    // Retry limit
    n_start = 0;
    load(2'd0, 11'h055, 18'h0, 1'b0, 1'b0, 4'd0, 64'h0);
    for (int k = 0; k < 3; k++) begin
      if (pending[0]) begin
        wait_start("t4_start");
        n_start++;
        step();
        arb_lost = 1'b1;
        step();
        arb_lost = 1'b0;
        check("t4_busy_retry", busy, 1);
        step();
      end
    end
    check("t4_fail", tx_fail, 4'b0001);
    check("t4_pend_clr", pending, 0);
`ifdef CAN_TX_SINGLE_SHOT_EN
    check("t4_starts", n_start, 1);
`else
    check("t4_starts", n_start, 2);
`endif
    step(); step(); step();
    check("t4_no_more_start", start_tx, 0);

    // Abort on active frame: tx_done still wins, arb_lost yields aborted
    load(2'd1, 11'h010, 18'h0, 1'b0, 1'b0, 4'd0, 64'h0);
    wait_start("t5_start_a");
    step();
    abort_req = 4'b0010;
    step();
    abort_req = 4'b0000;
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("t5_ok", tx_ok, 4'b0010);
    check("t5_not_aborted", tx_aborted, 0);
    load(2'd1, 11'h010, 18'h0, 1'b0, 1'b0, 4'd0, 64'h0);
    wait_start("t5_start_b");
    step();
    abort_req = 4'b0010;
    step();
    abort_req = 4'b0000;
    arb_lost = 1'b1;
    step();
    arb_lost = 1'b0;
    step();
    check("t5_aborted", tx_aborted, 4'b0010);
    check("t5_no_fail", tx_fail, 0);
    check("t5_pend", pending, 0);

    // Abort of a non-active pending mailbox and of an empty mailbox
    load(2'd1, 11'h010, 18'h0, 1'b0, 1'b0, 4'd0, 64'h0);
    load(2'd2, 11'h300, 18'h0, 1'b0, 1'b0, 4'd0, 64'h0);
    wait_start("t6_start");
    check("t6_id", tx_id_std, 11'h010);
    step();
    abort_req = 4'b1100;
    step();
    abort_req = 4'b0000;
    check("t6_aborted", tx_aborted, 4'b0100);
    check("t6_pend", pending, 4'b0010);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("t6_ok", tx_ok, 4'b0010);

    // Write to pending mailbox rejected, then reset mid-frame
    load(2'd0, 11'h222, 18'h0, 1'b0, 1'b0, 4'd1, 64'h11);
    load(2'd0, 11'h7FF, 18'h0, 1'b0, 1'b0, 4'd1, 64'h99);
    check("t7_wr_err", wr_err, 1);
    wait_start("t7_start");
    check("t7_id", tx_id_std, 11'h222);
    check("t7_data", tx_data, 64'h11);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t7_rst_busy", busy, 0);
    check("t7_rst_pend", pending, 0);
    check("t7_rst_id", tx_id_std, 0);
    check("t7_rst_ok", tx_ok, 0);
    load(2'd2, 11'h456, 18'h0, 1'b0, 1'b1, 4'd0, 64'h0);
    wait_start("t7_start_b");
    check("t7_id_b", tx_id_std, 11'h456);
    check("t7_remote", tx_remote_req, 1);
    finish_done();
    check("t7_ok_b", tx_ok, 4'b0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/can_tx_scheduler.md
Name: can_tx_scheduler

Overview:
- Multi-mailbox transmit scheduler that sits between the host/register interface and can_transmitter.
- Holds NUM_MB pending frames and picks the one that would win CAN bus arbitration (lowest arbitration key). Loads its fields into the transmitter, pulses start_tx and waits for completion.
- Handles arbitration-loss retry, host abort and per-mailbox status.

Parameters:
- NUM_MB, 4, number of transmit mailboxes (2..8).
- MAX_RETRY, 0, arbitration-loss retries before a frame is dropped; 0 = unlimited.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wr_en  in  1  mailbox load strobe
- wr_sel  in  $clog2(NUM_MB)  mailbox index for load
- wr_id_std  in  11  base identifier
- wr_id_ext  in  18  extended identifier
- wr_ide  in  1  1 = extended frame
- wr_rtr  in  1  1 = remote frame
- wr_dlc  in  4  data length code
- wr_data  in  64  data bytes; byte0 = [7:0]
- abort_req  in  NUM_MB  per-mailbox abort strobes
- tx_done  in  1  transmitter frame-complete pulse
- arb_lost  in  1  transmitter lost-arbitration pulse
- start_tx  out  1  one-cycle start pulse to transmitter
- tx_id_std, tx_id_ext, tx_ide, tx_rtr1, tx_rtr2, tx_remote_req, tx_dlc  out  11/18/1/1/1/1/4  frame fields held stable from start_tx until done/lost
- tx_data  out  64  selected mailbox data
- pending  out  NUM_MB  mailbox loaded and not yet resolved
- tx_ok, tx_fail, tx_aborted  out  NUM_MB each  one-cycle per-mailbox result pulses
- wr_err  out  1  pulse: write to a pending mailbox was rejected
- busy  out  1  frame handed to transmitter, not yet resolved

Behaviour:
- Reset:
  - All outputs 0; pending cleared; retry counters 0; FSM = IDLE.
  - Reset mid-frame drops the frame with no result pulse.
- Load:
  - wr_en with pending[wr_sel]=0 stores the fields and sets pending the next cycle.
  - wr_en with pending[wr_sel]=1 is ignored and pulses wr_err.
- Arbitration key (32 bits, lower wins):
  - {id_std, ide?1:rtr, ide, ide?id_ext:18'h0, ide?rtr:0}.
  - Ties go to the lower mailbox index.
  - Only pending, non-active mailboxes compete.
- Frame field mapping: tx_rtr1 = rtr for standard frames, 1 (SRR) for extended; tx_rtr2 = rtr; tx_remote_req = rtr.
- FSM:
  - IDLE: any pending -> SELECT.
  - SELECT (1 cycle): latch the winner index and load the output fields -> START.
  - START: start_tx=1 for exactly one cycle, busy=1 -> WAIT.
  - WAIT:
    - tx_done -> clear pending, pulse tx_ok, clear retry count -> IDLE.
    - arb_lost -> RETRY.
  - RETRY:
    - If abort is latched, clear pending and pulse tx_aborted.
    - Else increment the retry count; if MAX_RETRY != 0 and count == MAX_RETRY, clear pending and pulse tx_fail.
    - Then -> IDLE (re-arbitrate, so a newly loaded higher-priority frame can win).
- Latency: wr_en cycle T -> earliest start_tx at T+3.
- Simultaneous events:
  - tx_done and arb_lost in the same cycle: tx_done wins.
  - abort_req on the active mailbox is latched; tx_done still yields tx_ok, arb_lost yields tx_aborted.
  - abort_req on a non-active pending mailbox clears it next cycle with a tx_aborted pulse.
  - abort_req on an idle mailbox: no effect.
  - wr_en to a mailbox in the same cycle as its completion is rejected (still pending that cycle).
- busy stays 1 from START through the cycle before IDLE. Output fields hold their values while in IDLE.

Optional Feature:
- Macro: CAN_TX_SINGLE_SHOT_EN.
- Defined: arb_lost never retries; the frame is dropped immediately with a tx_fail pulse; MAX_RETRY is ignored and retry counters are not built.
- Undefined: retry behaviour as above.

Decomposition:
- can_defs.svh / can_pkg holds:
  - tx_sched_state_e (IDLE, SELECT, START, WAIT, RETRY).
  - typedef can_arb_key_t (32-bit).
  - typedef can_mb_t struct (id_std, id_ext, ide, rtr, dlc, data).
  - Function mk_arb_key().
- Sub-module can_tx_prio_select: combinational min-key finder over NUM_MB keys plus a valid mask, producing winner index and a found flag.

Test Plan:
- Load MB0 std id 0x123 dlc 2 data AB,CD -> start_tx at T+3, tx_id_std=0x123, tx_rtr1=0; after tx_done, tx_ok[0] pulse and pending=0.
- Load MB0 id 0x200 and MB2 id 0x100 in consecutive cycles -> MB2 sent first, then MB0; tx_ok order 2 then 0.
- MB1 std 0x155 vs MB3 ext base 0x155 ext 0x0 -> MB1 wins (std beats ext); MB3 drives tx_rtr1=1.
- MAX_RETRY=2, three arb_lost pulses on MB0 -> start_tx issued 2 times, then tx_fail[0]; with CAN_TX_SINGLE_SHOT_EN, tx_fail after the first arb_lost.
- abort_req[1] during WAIT on MB1: tx_done gives tx_ok[1]; arb_lost gives tx_aborted[1]. Abort of non-active pending MB2 gives tx_aborted[2] next cycle.
- wr_en to pending MB0 gives wr_err, data unchanged. rst asserted during WAIT: all outputs 0, pending=0, next load sends normally.
